// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE bundle for exe_stage, including the EXE/MEM-facing results.
interface exe_stage_if #(
    parameter int FWD_W = 2
);
    logic [3:0]       EXE_CMD;
    logic             MEM_R_EN;
    logic             MEM_W_EN;
    logic             WB_EN;
    logic             S;
    logic             imm;
    logic [31:0]      PC;
    logic [31:0]      Val_Rn;
    logic [31:0]      Val_Rm;
    logic [11:0]      Shift_operand;
    logic [23:0]      Signed_imm_24;
    logic [FWD_W-1:0] sel_src1;
    logic [FWD_W-1:0] sel_src2;
    logic [31:0]      mem_fwd_val;
    logic [31:0]      wb_fwd_val;
    logic [31:0]      ALU_result;
    logic [31:0]      Val_Rm_out;
    logic [31:0]      Br_addr;
    logic [3:0]       Status;
    logic             mul_stall;

    modport master (
        output EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, S, imm, PC,
               Val_Rn, Val_Rm, Shift_operand, Signed_imm_24,
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        input  ALU_result, Val_Rm_out, Br_addr, Status, mul_stall
    );

    modport slave (
        input  EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, S, imm, PC,
               Val_Rn, Val_Rm, Shift_operand, Signed_imm_24,
               sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        output ALU_result, Val_Rm_out, Br_addr, Status, mul_stall
    );
endinterface

// File: rtl/exe_stage.sv
// ARM execute stage: forwarding, Val2 shifter, ALU, NZCV and branch target.
// Define EXE_MUL_EN to build the iterative 32-cycle shift-add multiplier.
module exe_stage #(
    parameter int FWD_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);
    localparam logic [FWD_W-1:0] SEL_MEM = FWD_W'(1);
    localparam logic [FWD_W-1:0] SEL_WB  = FWD_W'(2);

    logic [31:0] op_a;
    logic [31:0] op_rm;
    logic [31:0] val2;
    logic [31:0] imm8;
    logic [5:0]  rot;
    logic [4:0]  amt;
    logic [31:0] res;
    logic [32:0] sum;
    logic        c_new;
    logic        v_new;
    logic [3:0]  status_q;
    logic        mul_stall;

    always_comb begin
        op_a = bus.Val_Rn;
        if (bus.sel_src1 == SEL_MEM)
            op_a = bus.mem_fwd_val;
        else if (bus.sel_src1 == SEL_WB)
            op_a = bus.wb_fwd_val;
    end

    always_comb begin
        op_rm = bus.Val_Rm;
        if (bus.sel_src2 == SEL_MEM)
            op_rm = bus.mem_fwd_val;
        else if (bus.sel_src2 == SEL_WB)
            op_rm = bus.wb_fwd_val;
    end

    assign bus.Val_Rm_out = op_rm;

    assign imm8 = {24'b0, bus.Shift_operand[7:0]};
    assign rot  = {1'b0, bus.Shift_operand[11:8], 1'b0};
    assign amt  = bus.Shift_operand[11:7];

    // A shift by 32 yields 0, so rotate-by-0 degenerates cleanly
    always_comb begin
        val2 = op_rm;
        if (bus.imm) begin
            val2 = (imm8 >> rot) | (imm8 << (6'd32 - rot));
        end else if (bus.MEM_R_EN | bus.MEM_W_EN) begin
            val2 = {20'b0, bus.Shift_operand};
        end else begin
            unique case (bus.Shift_operand[6:5])
                2'b00: val2 = op_rm << amt;
                2'b01: val2 = op_rm >> amt;
                2'b10: val2 = $signed(op_rm) >>> amt;
                2'b11: val2 = (op_rm >> amt)
                            | (op_rm << (6'd32 - {1'b0, amt}));
            endcase
        end
    end

`ifdef EXE_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t  state;
    mul_state_t  state_nxt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  count;
    logic        mul_req;

    assign mul_req = (bus.EXE_CMD == 4'b0000) & bus.WB_EN;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_stall = 1'b0;
        unique case (state)
            IDLE: begin
                if (mul_req) begin
                    mul_stall = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mul_stall = 1'b1;
                if (count == 5'd31)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (state == IDLE && mul_req) begin
            mcand  <= op_a;
            mplier <= op_rm;
            acc    <= '0;
            count  <= '0;
        end else if (state == BUSY) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = bus.WB_EN;
    assign mul_stall = 1'b0;
`endif

    // SUB/SBC use A + ~B + cin so the carry out is already NOT borrow
    always_comb begin
        res   = '0;
        sum   = '0;
        c_new = status_q[1];
        v_new = status_q[0];
        unique case (bus.EXE_CMD)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010, 4'b0011: begin
                sum = {1'b0, op_a} + {1'b0, val2}
                    + {32'b0, (bus.EXE_CMD[0] & status_q[1])};
                res   = sum[31:0];
                c_new = sum[32];
                v_new = (op_a[31] == val2[31]) && (res[31] != op_a[31]);
            end
            4'b0100, 4'b0101: begin
                sum = {1'b0, op_a} + {1'b0, ~val2}
                    + {32'b0, (bus.EXE_CMD[0] ? status_q[1] : 1'b1)};
                res   = sum[31:0];
                c_new = sum[32];
                v_new = (op_a[31] != val2[31]) && (res[31] != op_a[31]);
            end
            4'b0110: res = op_a & val2;
            4'b0111: res = op_a | val2;
            4'b1000: res = op_a ^ val2;
`ifdef EXE_MUL_EN
            4'b0000: res = acc;
`endif
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            status_q <= 4'b0000;
        else if (bus.S && !mul_stall)
            status_q <= {res[31], (res == 32'd0), c_new, v_new};
    end

    assign bus.ALU_result = res;
    assign bus.Status     = status_q;
    assign bus.mul_stall  = mul_stall;
    assign bus.Br_addr    = bus.PC
                          + {{6{bus.Signed_imm_24[23]}}, bus.Signed_imm_24, 2'b00};
endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline, between the ID/EXE pipeline register and the EXE/MEM pipeline register. It applies forwarding selects to the operands and generates Val2 from the shifter operand. It computes the ALU result and branch target, owns the NZCV status register, and runs an optional iterative 32-cycle multiplier that stalls the front end while busy.

## Interface
- `FWD_W`, default 2: forwarding select width.
- `clk`  in  1: pipeline clock.
- `rst`  in  1: synchronous, active-high reset.
- `EXE_CMD`  in  4: ALU opcode from ID/EXE register.
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN`, `S`, `imm`  in  1 each: control bits from ID/EXE register.
- `PC`  in  32: PC+4 of the instruction.
- `Val_Rn`, `Val_Rm`  in  32: register-file operands.
- `Shift_operand`  in  12: ARM shifter operand field.
- `Signed_imm_24`  in  24: branch offset.
- `sel_src1`, `sel_src2`  in  FWD_W: 00 = ID value, 01 = `mem_fwd_val`, 10 = `wb_fwd_val`, 11 = ID value.
- `mem_fwd_val`, `wb_fwd_val`  in  32: forwarded results.
- `ALU_result`  out  32: result to EXE/MEM register.
- `Val_Rm_out`  out  32: forwarded Rm, used as store data.
- `Br_addr`  out  32: branch target.
- `Status`  out  4: registered {N,Z,C,V}, fed back to ID condition check.
- `mul_stall`  out  1: freeze IF, ID and ID/EXE while high.

## Operation
- Operand A is `Val_Rn` after `sel_src1`. Operand Rm is `Val_Rm` after `sel_src2`, and it is driven on `Val_Rm_out`.
- Val2 selection:
  - `imm`=1: {24'b0, SO[7:0]} rotated right by 2*SO[11:8].
  - Else, if `MEM_R_EN|MEM_W_EN`: {20'b0, SO[11:0]}.
  - Else: Rm shifted by SO[11:7] using SO[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Shift amount 0 leaves Rm unchanged.
- ALU opcodes:
  - 0001 MOV: Val2. 1001 MVN: ~Val2.
  - 0010 ADD: A+Val2. 0011 ADC: A+Val2+C.
  - 0100 SUB: A−Val2. 0101 SBC: A−Val2−!C.
  - 0110 AND, 0111 ORR, 1000 EOR.
  - 0000 MUL: A*Rm, low 32 bits; requires EXE_MUL_EN.
  - Any other opcode: result 0.
- Flags:
  - N = result[31] and Z = (result==0) for every opcode.
  - Arithmetic ops: C = 33rd-bit carry; for SUB/SBC, C = NOT borrow. V = signed overflow.
  - Logical ops and MUL: C and V hold.
- `Status` loads the new flags on a clock edge where `S`=1 and `mul_stall`=0. Otherwise it holds.
- `Br_addr` = PC + (sign-extended `Signed_imm_24` << 2), modulo 2^32.
- Multiplier FSM (IDLE, BUSY, DONE):
  - mul_req = (EXE_CMD==0000) & WB_EN.
  - IDLE with mul_req: `mul_stall`=1 combinationally. At the edge, latch multiplicand=A and multiplier=Rm, clear the accumulator, set count=0, go to BUSY.
  - BUSY: one shift-add step per cycle and `mul_stall`=1. At count==31 go to DONE.
  - DONE: `mul_stall`=0 and `ALU_result` = product. Always return to IDLE; mul_req seen in DONE is ignored.
- Operands are latched at MUL start, so forwarding changes during BUSY have no effect.

## Timing
- The ALU, Val2, forwarding mux and `Br_addr` paths are combinational with 0-cycle latency. Only `Status`, the FSM state, the counter and the multiplier datapath are registered.
- MUL holds EXE for 34 cycles: 1 IDLE cycle, 32 BUSY cycles, 1 DONE cycle.
- `mul_stall` is high for the first 33 of those cycles. The next instruction enters EXE on the edge after DONE.
- Reset values: `Status`=0000, FSM=IDLE, count=0, accumulator=0, `mul_stall`=0.
- `ALU_result` after reset is the combinational value of the current inputs.
- `rst` mid-MUL aborts the operation: next cycle the FSM is in IDLE with `mul_stall`=0 and `Status` is cleared.
- `S`=1 on a MUL: the flag update occurs only at the DONE edge.
- A back-to-back MUL, i.e. a new mul_req in the cycle after DONE, starts a fresh 34-cycle operation.

## Configuration
- `EXE_MUL_EN` defined: the multiplier FSM and datapath are compiled in, with behaviour as above.
- `EXE_MUL_EN` undefined: no FSM or datapath is built. Opcode 0000 gives `ALU_result`=0, `mul_stall` is tied to 0, and the flags follow the normal N/Z rules.

## Test plan
- ADD: A=0x7FFFFFFF, Val2 = 1 (imm=1, SO=0x001), S=1 -> `ALU_result`=0x80000000, next-cycle `Status`=1001 (N,V).
- SBC: C=0, A=5, Rm=3 (SO=0x003) -> `ALU_result`=1. With S=1, `Status`=0010 (C=1, no borrow).
- Forwarding: sel_src1=01 with `mem_fwd_val`=0x10; sel_src2=10 with `wb_fwd_val`=0x4, MOV with LSL #2 (SO=0x103) -> `ALU_result`=0x10; `Val_Rm_out`=0x4.
- Immediate rotate, MOV with imm=1, SO=0x4FF -> `ALU_result`=0xFF000000. Branch with PC=0x100, imm24=0xFFFFFE -> `Br_addr`=0xF8.
- MUL (EXE_MUL_EN), A=0x12345, Rm=0x10 -> `mul_stall` high for exactly 33 cycles; in the DONE cycle `ALU_result`=0x123450 and `mul_stall`=0.
- `rst` pulsed at BUSY count 10 -> FSM back in IDLE with `mul_stall`=0; a following ADD completes in 1 cycle.
